mem_arbiter: RTL
================

# mem_arbiter

Two-requester, round-robin arbiter with bounded bursts, placed in front of a single-port synchronous memory (one access per clock, registered read data). It issues at most one memory command per cycle and returns read-valid strobes one cycle after each granted read. It lets two datapath clients share one memory instance without write/read collisions or starvation.

## Interface
- `width`, 32: data word width; matches the memory.
- `addr_width`, 2: address width; matches the memory.
- `max_burst`, 4: maximum consecutive grants to one requester while the other is waiting; legal range ≥1.

Ports:
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `req0`, `req1`  in  1: access request; held until granted.
- `we0`, `we1`  in  1: 1 = write, 0 = read; valid with req.
- `addr0`, `addr1`  in  addr_width: access address.
- `wdata0`, `wdata1`  in  width: write data.
- `gnt0`, `gnt1`  out  1: combinational grant; the access completes at this cycle's posedge.
- `rvalid0`, `rvalid1`  out  1: registered; read data valid this cycle.
- `rdata`  out  width: shared read data = `mem_R_data`; meaningful only with an rvalid.
- `mem_W_en`, `mem_R_en`  out  1: memory command strobes.
- `mem_W_addr`, `mem_R_addr`  out  addr_width: both driven with the winner's address.
- `mem_W_data`  out  width: winner's wdata.
- `mem_R_data`  in  width: memory read data, valid the cycle after `mem_R_en`.

## Operation
- State registers:
  - `last`, 1 bit: last requester granted.
  - `prev_gnt`, 1 bit: a grant occurred in the previous cycle.
  - `count`, $clog2(max_burst+1) bits: consecutive grants to `last`.
- Winner selection (combinational, p = `last`, q = ~`last`):
  - If `reset`: no grant.
  - Else if `req[p]` & `prev_gnt` & `count` < max_burst: grant p (burst continues).
  - Else if `req[q]`: grant q.
  - Else if `req[p]`: grant p.
  - Else: no grant.
- Consequences of the selection rule:
  - After an idle cycle or an exhausted burst, the other requester has priority.
  - A lone requester is granted every cycle indefinitely.
- Grant effects in the same cycle:
  - `gnt_w` = 1.
  - `mem_W_en` = `we_w`; `mem_R_en` = ~`we_w`.
  - Memory addresses = `addr_w`; `mem_W_data` = `wdata_w`.
- Never both `gnt0` and `gnt1`; never both `mem_W_en` and `mem_R_en`.
- No grant: all gnt/en outputs 0, addresses 0, `mem_W_data` 0.
- State update on grant to w:
  - If w == `last` & `prev_gnt`: `count` <= min(`count`+1, max_burst).
  - Else: `count` <= 1.
  - `last` <= w; `prev_gnt` <= 1.
- State update without a grant: `prev_gnt` <= 0; `last` and `count` hold.
- Read return: `rvalid_i` <= `gnt_i` & ~`we_i`. `rdata` passes `mem_R_data` through combinationally.

## Timing
- Reset values: `last` = 1 (requester 0 wins first contention), `prev_gnt` = 0, `count` = 0, `rvalid0`/`rvalid1` = 0.
- While `reset` is high: no grants and no memory strobes. An rvalid pending at the reset edge is dropped (0 the next cycle).
- Write latency: 0 cycles to grant. Memory updated at the grant-cycle posedge.
- Read latency: grant in cycle N; `rvalid` and data valid in cycle N+1. Back-to-back reads give `rvalid` every cycle.
- Same-address write by one requester then read by the other in the next cycle returns the new data.
- Worst-case wait for a requesting client is max_burst cycles. `count` saturates and never wraps.
- A request dropped mid-burst ends the burst. The next grant to that requester starts `count` at 1.

## Test plan
- Write then read, single requester: reset; `req0` write 0xDEADBEEF to addr 2, then read addr 2 → `gnt0` both cycles; `rvalid0` = 1 in the cycle after the read with `rdata` = 0xDEADBEEF; `rvalid1` stays 0.
- First contention after reset: `req0` = `req1` = 1 from the first post-reset cycle → `gnt0` first, and for max_burst(4) consecutive cycles; then `gnt1` for 4 cycles; alternating in blocks of 4, never both grants high.
- Lone requester: `req1` only, 10 cycles → `gnt1` all 10 cycles. `req0` rises at cycle 10 while `count` is saturated → `gnt0` at cycle 10.
- Idle-gap fairness: `gnt0` for 2 cycles, one idle cycle, then both request → `gnt1` wins first.
- Cross-port coherence: `req0` writes 0x5 to addr 1 in cycle N, `req1` reads addr 1 in cycle N+1 → `rvalid1` in N+2 with `rdata` = 0x5.
- Reset mid-read: read granted to 1 in cycle N, `reset` high in cycle N+1 → `rvalid1` = 0 in N+1 and N+2; after reset, contention grants 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory arbiter with bounded bursts
module mem_arbiter #(
    parameter int width      = 32,
    parameter int addr_width = 2,
    parameter int max_burst  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [width-1:0]      wdata0,
    input  logic [width-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [width-1:0]      rdata,
    output logic                  mem_W_en,
    output logic                  mem_R_en,
    output logic [addr_width-1:0] mem_W_addr,
    output logic [addr_width-1:0] mem_R_addr,
    output logic [width-1:0]      mem_W_data,
    input  logic [width-1:0]      mem_R_data
);

    localparam int cw = $clog2(max_burst + 1);
    localparam logic [cw-1:0] count_max = cw'(max_burst);

    logic          last_q, last_d;
    logic          prev_gnt_q, prev_gnt_d;
    logic [cw-1:0] count_q, count_d;
    logic          rvalid0_q, rvalid1_q;

    logic                  win_valid;
    logic                  win;
    logic                  req_p, req_q;
    logic                  we_w;
    logic [addr_width-1:0] addr_w;
    logic [width-1:0]      wdata_w;

    // Winner selection: continue an unexhausted burst, else favour the other side.
    always_comb begin
        win_valid = 1'b0;
        win       = 1'b0;
        req_p     = last_q ? req1 : req0;
        req_q     = last_q ? req0 : req1;
        if (!reset) begin
            if (req_p && prev_gnt_q && (count_q < count_max)) begin
                win_valid = 1'b1;
                win       = last_q;
            end else if (req_q) begin
                win_valid = 1'b1;
                win       = ~last_q;
            end else if (req_p) begin
                win_valid = 1'b1;
                win       = last_q;
            end
        end
    end

    assign we_w    = win ? we1 : we0;
    assign addr_w  = win ? addr1 : addr0;
    assign wdata_w = win ? wdata1 : wdata0;

    assign gnt0       = win_valid & ~win;
    assign gnt1       = win_valid & win;
    assign mem_W_en   = win_valid & we_w;
    assign mem_R_en   = win_valid & ~we_w;
    assign mem_W_addr = win_valid ? addr_w : '0;
    assign mem_R_addr = win_valid ? addr_w : '0;
    assign mem_W_data = win_valid ? wdata_w : '0;

    // A read strobe pending when reset rises is suppressed in that same cycle.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata   = mem_R_data;

    // Next-state for the burst tracking; count saturates rather than wrapping.
    always_comb begin
        last_d     = last_q;
        prev_gnt_d = 1'b0;
        count_d    = count_q;
        if (win_valid) begin
            last_d     = win;
            prev_gnt_d = 1'b1;
            if ((win == last_q) && prev_gnt_q) begin
                count_d = (count_q == count_max) ? count_q : count_q + cw'(1);
            end else begin
                count_d = cw'(1);
            end
        end
    end

    // State registers and registered read-valid strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q     <= 1'b1;
            prev_gnt_q <= 1'b0;
            count_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            prev_gnt_q <= prev_gnt_d;
            count_q    <= count_d;
            rvalid0_q  <= gnt0 & ~we0;
            rvalid1_q  <= gnt1 & ~we1;
        end
    end

endmodule
